// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types, opcode defaults and helpers for the SPI command sequencer.
package spi_seq_pkg;

  localparam logic [7:0] SEQ_WR_OP   = 8'hA1;
  localparam logic [7:0] SEQ_RD_OP   = 8'hA2;
  localparam int         INIT_ADDR_W = 16;
  localparam int         INIT_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5,
    ST_RESP = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic [INIT_ADDR_W-1:0] addr;
    logic [INIT_DATA_W-1:0] data;
  } init_entry_t;

  function automatic int frame_bytes(input int addr_w, input int data_w);
    return 1 + addr_w / 8 + data_w / 8;
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_init_rom.sv
// Combinational init register table replayed by the sequencer after reset.
module spi_init_rom import spi_seq_pkg::*; #(
  parameter int ENT_W = 4
) (
  input  logic [ENT_W-1:0] entry,
  output init_entry_t      value
);

  // Table lookup; unused indices read as zero.
  always_comb begin
    value = '{addr: 16'h0000, data: 16'h0000};
    case (32'(entry))
      32'd0:   value = '{addr: 16'h0030, data: 16'h0001};
      32'd1:   value = '{addr: 16'h00f3, data: 16'h0000};
      32'd2:   value = '{addr: 16'h00f9, data: 16'hc007};
      32'd3:   value = '{addr: 16'h0000, data: 16'h0000};
      32'd4:   value = '{addr: 16'h0001, data: 16'h0000};
      32'd5:   value = '{addr: 16'h0033, data: 16'h0001};
      32'd6:   value = '{addr: 16'h00a0, data: 16'h0000};
      32'd7:   value = '{addr: 16'h00a2, data: 16'h0001};
      32'd8:   value = '{addr: 16'h0038, data: 16'h0000};
      32'd9:   value = '{addr: 16'h0031, data: 16'h0001};
      default: value = '{addr: 16'h0000, data: 16'h0000};
    endcase
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Serialises host/init register commands into opcode/address/data SPI frames.
// Optional watchdog abort on a stalled SPI master: define SPI_SEQ_TIMEOUT_EN.
module spi_cmd_sequencer import spi_seq_pkg::*; #(
  parameter int         ADDR_W      = 16,
  parameter int         DATA_W      = 16,
  parameter int         INIT_DEPTH  = 10,
  parameter logic [7:0] WR_OP       = SEQ_WR_OP,
  parameter logic [7:0] RD_OP       = SEQ_RD_OP,
  parameter int         FRAME_BYTES = frame_bytes(ADDR_W, DATA_W)
) (
  input  logic                             clk40M,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [7:0]                       cmd_op,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [DATA_W-1:0]                cmd_data,
  output logic                             rsp_valid,
  output logic [DATA_W-1:0]                rsp_data,
  output logic                             rsp_err,
  output logic                             init_done,
  output logic                             busy,
  output logic [$clog2(FRAME_BYTES+1)-1:0] spi_tx_count,
  output logic [7:0]                       spi_tx_byte,
  output logic                             spi_tx_dv,
  input  logic                             spi_tx_ready,
  input  logic                             spi_rx_dv,
  input  logic [7:0]                       spi_rx_byte
);

  localparam int IDX_W   = $clog2(FRAME_BYTES + 1);
  localparam int ENT_W   = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;
  localparam int FRAME_W = 8 * FRAME_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] RX_FIRST = IDX_W'(1 + ADDR_W / 8);
  localparam logic [IDX_W-1:0] RX_FULL  = IDX_W'(FRAME_BYTES);
  localparam logic [ENT_W-1:0] LAST_ENT = ENT_W'((INIT_DEPTH > 0) ? INIT_DEPTH - 1 : 0);

  seq_state_t           state_r;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     rx_cnt_r;
  logic [ENT_W-1:0]     entry_r;
  logic [FRAME_W-1:0]   frame_r;
  logic [DATA_W-1:0]    rd_data_r;
  logic                 is_init_r;
  logic                 is_read_r;
  logic                 err_pend_r;
  logic                 ready_q_r;

  init_entry_t          rom_entry_s;
  logic [FRAME_W-1:0]   init_frame_s;
  logic [FRAME_W-1:0]   host_frame_s;
  logic [7:0]           tx_byte_s;
  logic                 ready_rise_s;
  logic                 wdog_hit_s;

  spi_init_rom #(.ENT_W(ENT_W)) u_rom (
    .entry (entry_r),
    .value (rom_entry_s)
  );

  assign spi_tx_count = IDX_W'(FRAME_BYTES);

  // Frame images are little-endian byte vectors: byte 0 is the opcode.
  always_comb begin
    ready_rise_s = spi_tx_ready & ~ready_q_r;
    init_frame_s = {DATA_W'(rom_entry_s.data), ADDR_W'(rom_entry_s.addr), WR_OP};
    host_frame_s = {(cmd_op == RD_OP) ? {DATA_W{1'b0}} : cmd_data, cmd_addr, cmd_op};
    tx_byte_s    = 8'(frame_r >> {idx_r, 3'b000});
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [15:0] wdog_r;

  // Watchdog runs only while waiting on the SPI master; each strobe restarts it.
  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) begin
      wdog_r <= 16'h0000;
    end else if ((state_r == ST_WAIT || state_r == ST_DONE) && wdog_r != 16'hFFFF) begin
      wdog_r <= wdog_r + 16'h0001;
    end else if (state_r != ST_WAIT && state_r != ST_DONE) begin
      wdog_r <= 16'h0000;
    end
  end

  assign wdog_hit_s = (wdog_r == 16'hFFFF);
`else
  assign wdog_hit_s = 1'b0;
`endif

  // Sequencer FSM with registered handshake, response and SPI strobe outputs.
  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) begin
      state_r     <= ST_INIT;
      idx_r       <= '0;
      rx_cnt_r    <= '0;
      entry_r     <= '0;
      frame_r     <= '0;
      rd_data_r   <= '0;
      is_init_r   <= 1'b0;
      is_read_r   <= 1'b0;
      err_pend_r  <= 1'b0;
      ready_q_r   <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      init_done   <= 1'b0;
      busy        <= 1'b0;
      spi_tx_byte <= 8'h00;
      spi_tx_dv   <= 1'b0;
    end else begin
      ready_q_r <= spi_tx_ready;
      spi_tx_dv <= 1'b0;
      rsp_valid <= 1'b0;

      // rx bytes past the address phase shift in from the top, so LSB-first lands in order.
      if (state_r != ST_LOAD && spi_rx_dv && rx_cnt_r != RX_FULL) begin
        rx_cnt_r <= rx_cnt_r + IDX_W'(1);
        if (rx_cnt_r >= RX_FIRST) begin
          rd_data_r <= DATA_W'({spi_rx_byte, rd_data_r} >> 8);
        end
      end

      case (state_r)
        ST_INIT: begin
          is_read_r <= 1'b0;
          if (INIT_DEPTH == 0) begin
            init_done <= 1'b1;
            cmd_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            is_init_r <= 1'b1;
            state_r   <= ST_LOAD;
          end
        end
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            frame_r   <= host_frame_s;
            is_init_r <= 1'b0;
            is_read_r <= (cmd_op == RD_OP);
            if (cmd_op != WR_OP && cmd_op != RD_OP) begin
              err_pend_r <= 1'b1;
              state_r    <= ST_RESP;
            end else begin
              err_pend_r <= 1'b0;
              state_r    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          idx_r     <= '0;
          rx_cnt_r  <= '0;
          rd_data_r <= '0;
          busy      <= 1'b1;
          if (is_init_r) begin
            frame_r <= init_frame_s;
          end
          state_r <= ST_SEND;
        end
        ST_SEND: begin
          if (spi_tx_ready) begin
            spi_tx_byte <= tx_byte_s;
            spi_tx_dv   <= 1'b1;
            state_r     <= ST_WAIT;
          end
        end
        ST_WAIT, ST_DONE: begin
          if (wdog_hit_s) begin
            if (is_init_r) begin
              is_init_r <= 1'b0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state_r   <= ST_IDLE;
            end else begin
              err_pend_r <= 1'b1;
              state_r    <= ST_RESP;
            end
          end else if (state_r == ST_WAIT) begin
            if (ready_rise_s) begin
              if (idx_r == LAST_IDX) begin
                state_r <= ST_DONE;
              end else begin
                idx_r   <= idx_r + IDX_W'(1);
                state_r <= ST_SEND;
              end
            end
          end else if (!is_read_r || rx_cnt_r == RX_FULL) begin
            if (is_init_r) begin
              entry_r <= entry_r + ENT_W'(1);
              if (entry_r == LAST_ENT) begin
                init_done <= 1'b1;
                is_init_r <= 1'b0;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                state_r   <= ST_IDLE;
              end else begin
                state_r <= ST_LOAD;
              end
            end else begin
              state_r <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_pend_r;
          rsp_data  <= (is_read_r && !err_pend_r) ? rd_data_r : '0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_INIT;
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a small byte-level SPI master model.
module tb_spi_cmd_sequencer;

  logic        clk40M = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = 8'h00;
  logic [15:0] cmd_addr = 16'h0000;
  logic [15:0] cmd_data = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        init_done;
  logic        busy;
  logic [2:0]  spi_tx_count;
  logic [7:0]  spi_tx_byte;
  logic        spi_tx_dv;
  logic        spi_tx_ready = 1'b1;
  logic        spi_rx_dv = 1'b0;
  logic [7:0]  spi_rx_byte = 8'h00;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_log[$];
  logic [7:0] rx_q[$];
  int stall_at = 0;
  int delay = 0;
  int viol = 0;
  int rsp_cnt = 0;
  logic [15:0] last_data = 16'h0000;
  logic last_err = 1'b0;
  int bad_ready = 0;
  int bad_rsp = 0;
  int strobes_at_done = -1;
  logic init_prev = 1'b0;

  spi_cmd_sequencer dut (
    .clk40M(clk40M), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .init_done(init_done), .busy(busy), .spi_tx_count(spi_tx_count),
    .spi_tx_byte(spi_tx_byte), .spi_tx_dv(spi_tx_dv), .spi_tx_ready(spi_tx_ready),
    .spi_rx_dv(spi_rx_dv), .spi_rx_byte(spi_rx_byte)
  );

  always #5 clk40M = ~clk40M;

  // SPI master model and output monitor, evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk40M);
      spi_rx_dv = 1'b0;
      if (rst) begin
        spi_tx_ready = 1'b1;
        delay = 0;
        init_prev = 1'b0;
      end else begin
        if (spi_tx_dv) begin
          if (!spi_tx_ready) viol++;
          tx_log.push_back(spi_tx_byte);
          spi_tx_ready = 1'b0;
          delay = 3;
        end else if (!spi_tx_ready && !(stall_at != 0 && tx_log.size() >= stall_at)) begin
          delay--;
          if (delay == 0) begin
            spi_tx_ready = 1'b1;
            spi_rx_dv = 1'b1;
            spi_rx_byte = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
          end
        end
        if (rsp_valid) begin
          rsp_cnt++;
          last_data = rsp_data;
          last_err = rsp_err;
        end
        if (!init_done && cmd_ready) bad_ready++;
        if (!init_done && rsp_valid) bad_rsp++;
        if (init_done && !init_prev) strobes_at_done = tx_log.size();
        init_prev = init_done;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int base, input logic [39:0] exp);
    logic [15:0] obs;
    for (int i = 0; i < 5; i++) begin
      obs = (base + i < tx_log.size()) ? {8'h00, tx_log[base + i]} : 16'h0100;
      check($sformatf("%s_byte%0d", tag, i), {16'h0000, obs}, {24'h000000, exp[(4 - i) * 8 +: 8]});
    end
  endtask

  task automatic wait_log(input int n, input string tag);
    int cyc = 0;
    while (tx_log.size() < n && cyc < 2000) begin
      @(negedge clk40M);
      cyc++;
    end
    check({tag, "_log_wait"}, {31'd0, tx_log.size() >= n}, 32'd1);
  endtask

  task automatic wait_rsp(input int prev, input int budget, input string tag);
    int cyc = 0;
    while (rsp_cnt == prev && cyc < budget) begin
      @(negedge clk40M);
      cyc++;
    end
    check({tag, "_rsp_wait"}, {31'd0, rsp_cnt != prev}, 32'd1);
  endtask

  task automatic wait_init(input string tag);
    int cyc = 0;
    while (!init_done && cyc < 5000) begin
      @(negedge clk40M);
      cyc++;
    end
    check({tag, "_init_wait"}, {31'd0, init_done}, 32'd1);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [15:0] data);
    int cyc = 0;
    while (!cmd_ready && cyc < 2000) begin
      @(negedge clk40M);
      cyc++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = addr;
    cmd_data = data;
    @(negedge clk40M);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int prev;
    repeat (3) @(negedge clk40M);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_byte", {24'd0, spi_tx_byte}, 32'd0);
    check("rst_tx_dv", {31'd0, spi_tx_dv}, 32'd0);
    check("tx_count", {29'd0, spi_tx_count}, 32'd5);

    // Init replay: ten 5-byte write frames.
    rst = 1'b0;
    wait_init("init");
    check("init_strobes", strobes_at_done, 32'd50);
    check_frame("init_first", 0, 40'hA1_30_00_01_00);
    check_frame("init_last", 45, 40'hA1_31_00_01_00);
    check("init_cmd_ready_low", bad_ready, 32'd0);
    check("init_no_rsp", bad_rsp, 32'd0);
    check("init_busy_clear", {31'd0, busy}, 32'd0);
    check("post_init_ready", {31'd0, cmd_ready}, 32'd1);

    // Host write.
    tx_log.delete();
    prev = rsp_cnt;
    send_cmd(8'hA1, 16'h1234, 16'hBEEF);
    wait_rsp(prev, 2000, "wr");
    repeat (3) @(negedge clk40M);
    check("wr_rsp_count", rsp_cnt, prev + 1);
    check("wr_rsp_err", {31'd0, last_err}, 32'd0);
    check("wr_rsp_data", {16'd0, last_data}, 32'd0);
    check("wr_len", tx_log.size(), 32'd5);
    check_frame("wr", 0, 40'hA1_34_12_EF_BE);

    // Bad opcode: error response two cycles after acceptance, no SPI traffic.
    tx_log.delete();
    prev = rsp_cnt;
    check("bad_pre_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op = 8'h55;
    cmd_addr = 16'h0001;
    cmd_data = 16'h0002;
    @(negedge clk40M);
    cmd_valid = 1'b0;
    check("bad_accepted", {31'd0, cmd_ready}, 32'd0);
    check("bad_rsp_not_yet", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk40M);
    check("bad_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bad_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("bad_rsp_data", {16'd0, rsp_data}, 32'd0);
    repeat (5) @(negedge clk40M);
    check("bad_no_tx", tx_log.size(), 32'd0);

    // Stall mid-frame for 1000 cycles.
    tx_log.delete();
    prev = rsp_cnt;
    stall_at = 2;
    send_cmd(8'hA1, 16'h0055, 16'h1122);
    wait_log(2, "stall");
    repeat (1000) @(negedge clk40M);
    check("stall_len", tx_log.size(), 32'd2);
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_no_rsp", rsp_cnt, prev);
    stall_at = 0;
    wait_rsp(prev, 2000, "stall");
    repeat (2) @(negedge clk40M);
    check("stall_rsp_err", {31'd0, last_err}, 32'd0);
    check_frame("stall", 0, 40'hA1_55_00_22_11);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog abort on a master that never recovers.
    tx_log.delete();
    prev = rsp_cnt;
    stall_at = 1;
    send_cmd(8'hA1, 16'h0066, 16'h7788);
    wait_rsp(prev, 70000, "tmo");
    repeat (2) @(negedge clk40M);
    check("tmo_rsp_err", {31'd0, last_err}, 32'd1);
    check("tmo_rsp_data", {16'd0, last_data}, 32'd0);
    stall_at = 0;
    repeat (10) @(negedge clk40M);
`endif

    // Host read: data phase transmits zeros, rx bytes 3..4 form the result.
    tx_log.delete();
    rx_q = '{8'h00, 8'h00, 8'h00, 8'hCD, 8'hAB};
    prev = rsp_cnt;
    send_cmd(8'hA2, 16'h0040, 16'hFFFF);
    wait_rsp(prev, 2000, "rd");
    repeat (2) @(negedge clk40M);
    check("rd_rsp_data", {16'd0, last_data}, 32'h0000ABCD);
    check("rd_rsp_err", {31'd0, last_err}, 32'd0);
    check_frame("rd", 0, 40'hA2_40_00_00_00);

    // Reset during the third byte of a host write.
    tx_log.delete();
    send_cmd(8'hA1, 16'h1234, 16'hBEEF);
    wait_log(3, "mid");
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    check("mid_rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("mid_rst_tx_byte", {24'd0, spi_tx_byte}, 32'd0);
    check("mid_rst_tx_dv", {31'd0, spi_tx_dv}, 32'd0);
    repeat (3) @(negedge clk40M);
    tx_log.delete();
    rx_q.delete();
    strobes_at_done = -1;
    bad_ready = 0;
    bad_rsp = 0;
    rst = 1'b0;
    wait_init("reinit");
    check("reinit_strobes", strobes_at_done, 32'd50);
    check_frame("reinit_first", 0, 40'hA1_30_00_01_00);
    check("reinit_cmd_ready_low", bad_ready, 32'd0);
    check("reinit_no_rsp", bad_rsp, 32'd0);
    check("strobe_while_not_ready", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
Parametrised successor of the fixed 5-byte SPI write front-end. It accepts host register commands over a valid/ready handshake and serialises each into an opcode/address/data frame for the byte-level SPI master (SPI_Master_With_Single_CS). It supports both write and read-back opcodes and returns read data. After reset it autonomously replays a parametrised init register table, then serves host commands.

Parameters:
ADDR_W, 16, register address width in bits; multiple of 8, 8..32
DATA_W, 16, register data width in bits; multiple of 8, 8..32
INIT_DEPTH, 10, number of init table entries; 0 = no init sequence
WR_OP, 8'hA1, write opcode
RD_OP, 8'hA2, read opcode
FRAME_BYTES, 1+ADDR_W/8+DATA_W/8, derived; bytes per chip-select frame

Ports:
clk40M  in  1  single system clock
rst  in  1  reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  8  opcode
cmd_addr  in  ADDR_W  register address
cmd_data  in  DATA_W  write data (ignored for read)
rsp_valid  out  1  one-cycle pulse: command finished
rsp_data  out  DATA_W  read data (0 for writes)
rsp_err  out  1  qualifies rsp_valid: bad opcode (or timeout)
init_done  out  1  init table fully sent; sticky until reset
busy  out  1  frame in progress (init or host)
spi_tx_count  out  $clog2(FRAME_BYTES+1)  constant FRAME_BYTES
spi_tx_byte  out  8  byte to SPI master
spi_tx_dv  out  1  one-cycle byte strobe
spi_tx_ready  in  1  SPI master ready
spi_rx_dv  in  1  SPI master received-byte strobe
spi_rx_byte  in  8  received byte

Interface note: one clock, clk40M; rst is asynchronous and active-high.

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0, busy=0, spi_tx_byte=0, spi_tx_dv=0. State=INIT, byte index=0, entry index=0.
- Frame order: opcode, then address bytes LSB first, then data bytes LSB first. Read frames send 8'h00 in the data phase.
- Byte pacing: spi_tx_dv pulses only while spi_tx_ready=1. The next byte is issued only after a registered rising edge of spi_tx_ready following the previous strobe. Consecutive strobes are never adjacent.
- Read capture: count spi_rx_dv pulses per frame. rx bytes with index >= 1+ADDR_W/8 fill rsp_data LSB first. Opcode/address-phase rx bytes are discarded.
- States:
  - INIT: if INIT_DEPTH=0 go to IDLE and set init_done; else go to LOAD with an init entry (op=WR_OP, addr/data from the ROM).
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/addr/data into a frame register.
    - op not in {WR_OP,RD_OP}: go to RESP with rsp_err=1; no SPI activity.
    - Otherwise go to LOAD.
  - LOAD: index=0, busy=1, go to SEND.
  - SEND: drive byte[index], spi_tx_dv=1 for one cycle, go to WAIT.
  - WAIT: on ready rising edge:
    - index==FRAME_BYTES-1: go to DONE.
    - Otherwise index+1 and go to SEND.
  - DONE: for a read, wait for the final spi_rx_dv. Then:
    - Init frame: entry+1. If entry==INIT_DEPTH-1, set init_done and go to IDLE; else go to LOAD.
    - Host frame: go to RESP.
  - RESP: rsp_valid=1 for one cycle, busy=0, go to IDLE.
- Init entries never produce rsp_valid. cmd_ready=0 throughout init.
- cmd_ready is low in every state except IDLE. Commands presented while busy are held by the host, never dropped.
- Simultaneous ready edge and rx_dv in one cycle: both are processed.
- rst mid-frame: immediate return to reset values. The init sequence restarts from entry 0.

Optional Feature:
SPI_SEQ_TIMEOUT_EN:
- Defined: a 16-bit watchdog counts cycles in WAIT/DONE and clears on each strobe.
  - Reaching 16'hFFFF aborts the frame and goes to RESP with rsp_err=1 and rsp_data=0.
  - During init, it aborts the remaining init, leaves init_done=0, and goes to IDLE.
- Undefined: no counter; WAIT blocks indefinitely.

Decomposition:
- Package spi_seq_pkg: state enum, WR_OP/RD_OP defaults, FRAME_BYTES function, init entry struct {addr, data}.
- One sub-module, spi_init_rom: combinational, indexed by entry, returns the init entry.
- The default table is the current ten-entry ADDI init set:
  - 0030/0001, 00f3/0000, 00f9/c007, 0000/0000, 0001/0000
  - 0033/0001, 00a0/0000, 00a2/0001, 0038/0000, 0031/0001

Test Plan:
- Reset release with the SPI model always ready -> 10 frames of 5 bytes each. First frame is A1,30,00,01,00; init_done rises after the 50th strobe; cmd_ready stays 0 until then.
- Write A1/addr 1234/data BEEF -> strobes A1,34,12,EF,BE; one rsp_valid with rsp_err=0 and rsp_data=0.
- Read A2/addr 0040, model returns rx 00,00,00,CD,AB -> tx A2,40,00,00,00; rsp_data=16'hABCD.
- Opcode 8'h55 -> no spi_tx_dv; rsp_valid with rsp_err=1 two cycles after acceptance.
- spi_tx_ready held low 1000 cycles mid-frame -> no further strobes. With SPI_SEQ_TIMEOUT_EN, holding it low 65536 cycles -> rsp_err=1.
- Assert rst during the third byte of a host write -> outputs return to reset values; init restarts with A1,30,00,01,00.
